// File: rtl/instr_fetch_if.sv
// Signal bundle for the fetch stage: program-memory read port, branch redirect
// input and the instruction-register handshake toward the decoder.
interface instr_fetch_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int OPERAND_WIDTH = 11,
    parameter int ADDR_WIDTH    = 11
);
    localparam int OPCODE_WIDTH = DATA_WIDTH - OPERAND_WIDTH;

    logic                     mem_req;
    logic [ADDR_WIDTH-1:0]    mem_addr;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic                     mem_ack;
    logic                     branch_en;
    logic [ADDR_WIDTH-1:0]    branch_addr;
    logic                     ir_valid;
    logic                     ir_ready;
    logic [OPCODE_WIDTH-1:0]  opcode_out;
    logic [OPERAND_WIDTH-1:0] operand_out;
    logic [ADDR_WIDTH-1:0]    pc_out;
    logic                     halted;

    modport master (
        output mem_req, mem_addr, ir_valid, opcode_out, operand_out, pc_out, halted,
        input  mem_rdata, mem_ack, branch_en, branch_addr, ir_ready
    );

    modport slave (
        input  mem_req, mem_addr, ir_valid, opcode_out, operand_out, pc_out, halted,
        output mem_rdata, mem_ack, branch_en, branch_addr, ir_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage of the accumulator CPU: req/ack instruction reads into an IR with valid/ready
// delivery and branch redirects. Define HALT_DETECT_EN to stop fetching after an opcode-0 word.
module instr_fetch #(
    parameter int DATA_WIDTH    = 16,
    parameter int OPERAND_WIDTH = 11,
    parameter int ADDR_WIDTH    = 11
) (
    input logic           clk,
    input logic           rst_n,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {S_GAP, S_FETCH, S_VALID, S_HALT} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [ADDR_WIDTH-1:0]   pc_out_q;
    logic [DATA_WIDTH-1:0]   ir;
    logic                    mem_req_q;
    logic                    ir_valid_q;
    logic                    discard;

`ifdef HALT_DETECT_EN
    logic                    halt_q;
    logic                    halt_word;

    assign halt_word  = (ir[DATA_WIDTH-1:OPERAND_WIDTH] == '0);
    assign bus.halted = halt_q;
`else
    assign bus.halted = 1'b0;
`endif

    // discard marks an open read whose address was overtaken by a branch; it must
    // still complete on the bus, but its data never reaches the IR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_GAP;
            pc         <= '0;
            mem_addr_q <= '0;
            pc_out_q   <= '0;
            ir         <= '0;
            mem_req_q  <= 1'b0;
            ir_valid_q <= 1'b0;
            discard    <= 1'b0;
`ifdef HALT_DETECT_EN
            halt_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_GAP: begin
                    mem_req_q <= 1'b1;
                    state     <= S_FETCH;
                    if (bus.branch_en) begin
                        pc         <= bus.branch_addr;
                        mem_addr_q <= bus.branch_addr;
                    end else begin
                        mem_addr_q <= pc;
                    end
                end
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        discard   <= 1'b0;
                        if (bus.branch_en) begin
                            pc    <= bus.branch_addr;
                            state <= S_GAP;
                        end else if (discard) begin
                            state <= S_GAP;
                        end else begin
                            ir         <= bus.mem_rdata;
                            pc_out_q   <= mem_addr_q;
                            pc         <= pc + ADDR_WIDTH'(1);
                            ir_valid_q <= 1'b1;
                            state      <= S_VALID;
                        end
                    end else if (bus.branch_en) begin
                        pc      <= bus.branch_addr;
                        discard <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (bus.branch_en) begin
                        ir_valid_q <= 1'b0;
                        pc         <= bus.branch_addr;
                        state      <= S_GAP;
                    end else if (bus.ir_ready) begin
                        ir_valid_q <= 1'b0;
`ifdef HALT_DETECT_EN
                        if (halt_word) begin
                            halt_q <= 1'b1;
                            state  <= S_HALT;
                        end else
`endif
                        begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= pc;
                            state      <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.ir_valid    = ir_valid_q;
    assign bus.opcode_out  = ir[DATA_WIDTH-1:OPERAND_WIDTH];
    assign bus.operand_out = ir[OPERAND_WIDTH-1:0];
    assign bus.pc_out      = pc_out_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios followed by randomized memory, branch and
// decoder traffic, checked against an instruction-stream model of program order.
module tb_instr_fetch;
    localparam int DW = 16;
    localparam int OW = 11;
    localparam int AW = 11;
    localparam int CW = DW - OW;

`ifdef HALT_DETECT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_if #(.DATA_WIDTH(DW), .OPERAND_WIDTH(OW), .ADDR_WIDTH(AW)) bus ();

    instr_fetch #(.DATA_WIDTH(DW), .OPERAND_WIDTH(OW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] expPc;
    bit            stale;
    bit            modelHalted;
    int            idleCycles;
    int            compared = 0;
    int            mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        checkOutput("rst_opcode", 32'(bus.opcode_out), 32'd0);
        checkOutput("rst_operand", 32'(bus.operand_out), 32'd0);
        checkOutput("rst_pc_out", 32'(bus.pc_out), 32'd0);
        checkOutput("rst_halted", 32'(bus.halted), 32'd0);
    endtask

    // Called #1 after a rising edge; an ack is held during reset to prove it is ignored.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_req_drop", 32'(bus.mem_req), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hFFFF;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        checkResetValues();
        rst_n       = 1'b1;
        expPc       = '0;
        stale       = 1'b0;
        modelHalted = 1'b0;
        idleCycles  = 0;
    endtask

    // One clock: drive inputs, take the edge, then compare the DUT against program order.
    task automatic applyStimulus(input bit ack, input bit ready, input bit br, input logic [AW-1:0] brAddr);
        logic          reqB;
        logic          validB;
        logic [AW-1:0] addrB;
        logic [AW-1:0] pcOutB;
        logic [DW-1:0] irB;
        logic [DW-1:0] word;
        bit            branchTaken;

        reqB   = bus.mem_req;
        validB = bus.ir_valid;
        addrB  = bus.mem_addr;
        pcOutB = bus.pc_out;
        irB    = {bus.opcode_out, bus.operand_out};

        bus.mem_ack     = ack;
        bus.mem_rdata   = ack ? mem[addrB] : DW'($urandom);
        bus.ir_ready    = ready;
        bus.branch_en   = br;
        bus.branch_addr = brAddr;
        @(posedge clk);
        #1;
        bus.mem_ack   = 1'b0;
        bus.branch_en = 1'b0;

        branchTaken = br && !modelHalted;

        if (validB && ready && !branchTaken) begin
            word = mem[expPc];
            checkOutput("deliver_pc", 32'(pcOutB), 32'(expPc));
            checkOutput("deliver_word", 32'(irB), 32'(word));
            checkOutput("deliver_valid_drop", 32'(bus.ir_valid), 32'd0);
            expPc = expPc + AW'(1);
            if (HALT && word[DW-1:OW] == '0) modelHalted = 1'b1;
        end else if (validB && branchTaken) begin
            checkOutput("flush_valid", 32'(bus.ir_valid), 32'd0);
        end else if (validB) begin
            checkOutput("hold_valid", 32'(bus.ir_valid), 32'd1);
            checkOutput("hold_pc_out", 32'(bus.pc_out), 32'(pcOutB));
            checkOutput("hold_ir", 32'({bus.opcode_out, bus.operand_out}), 32'(irB));
            checkOutput("hold_no_req", 32'(bus.mem_req), 32'd0);
        end

        if (branchTaken) begin
            expPc = brAddr;
            if (reqB) stale = 1'b1;
        end

        if (reqB && ack) begin
            if (!stale) begin
                checkOutput("ack_fetch_addr", 32'(addrB), 32'(expPc));
                checkOutput("ack_valid", 32'(bus.ir_valid), 32'd1);
                checkOutput("ack_pc_out", 32'(bus.pc_out), 32'(addrB));
                checkOutput("ack_word", 32'({bus.opcode_out, bus.operand_out}), 32'(mem[addrB]));
            end else begin
                checkOutput("discard_valid", 32'(bus.ir_valid), 32'd0);
            end
            stale = 1'b0;
            checkOutput("ack_req_gap", 32'(bus.mem_req), 32'd0);
        end else if (reqB) begin
            checkOutput("req_hold", 32'(bus.mem_req), 32'd1);
            checkOutput("addr_hold", 32'(bus.mem_addr), 32'(addrB));
        end else if (bus.mem_req) begin
            checkOutput("req_addr", 32'(bus.mem_addr), 32'(expPc));
        end

        if (!validB && !(reqB && ack)) checkOutput("valid_spurious", 32'(bus.ir_valid), 32'd0);
        if (modelHalted) checkOutput("halt_no_req", 32'(bus.mem_req), 32'd0);
        checkOutput("halted", 32'(bus.halted), 32'(modelHalted));

        if (!bus.mem_req && !bus.ir_valid && !modelHalted) idleCycles++;
        else idleCycles = 0;
        if (idleCycles >= 3) begin
            checkOutput("liveness_req", 32'(bus.mem_req), 32'd1);
            idleCycles = 0;
        end
    endtask

    initial begin
        int haltCycles;
        logic [DW-1:0] w;
        logic          ack;

        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        bus.ir_ready    = 1'b0;
        bus.branch_en   = 1'b0;
        bus.branch_addr = '0;
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
        mem[0]     = 16'hA7FF;
        mem[11'h050] = 16'h8050;
        mem[11'h7FF] = 16'h3ABC;

        doReset();

        // First fetch after reset, IR field split
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("t1_req", 32'(bus.mem_req), 32'd1);
        checkOutput("t1_addr", 32'(bus.mem_addr), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("t1_valid", 32'(bus.ir_valid), 32'd1);
        checkOutput("t1_opcode", 32'(bus.opcode_out), 32'h14);
        checkOutput("t1_operand", 32'(bus.operand_out), 32'h7FF);
        checkOutput("t1_pc_out", 32'(bus.pc_out), 32'd0);

        // Decoder back-pressure, then release
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("t2_req_idle", 32'(bus.mem_req), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("t2_valid", 32'(bus.ir_valid), 32'd0);
        checkOutput("t2_req", 32'(bus.mem_req), 32'd1);
        checkOutput("t2_addr", 32'(bus.mem_addr), 32'd1);

        // Branch while a read is open
        applyStimulus(1'b0, 1'b0, 1'b1, 11'h123);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("t3_no_valid", 32'(bus.ir_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("t3_req", 32'(bus.mem_req), 32'd1);
        checkOutput("t3_addr", 32'(bus.mem_addr), 32'h123);

        // Branch coincident with ack, then a flush of a held IR
        applyStimulus(1'b1, 1'b0, 1'b1, 11'h050);
        checkOutput("t4_no_valid", 32'(bus.ir_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("t4_addr", 32'(bus.mem_addr), 32'h050);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, 11'h7FF);
        checkOutput("t4_flush", 32'(bus.ir_valid), 32'd0);

        // Program counter wrap
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("t5_pc_out", 32'(bus.pc_out), 32'h7FF);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("t5_wrap_addr", 32'(bus.mem_addr), 32'd0);

        // Opcode-0 word; reset lands mid-transaction
        mem[0] = 16'h0005;
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 11'h200);
        checkOutput("t6_halted", 32'(bus.halted), 32'(HALT));
        checkOutput("t6_req", 32'(bus.mem_req), 32'(!HALT));
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("t6_restart_req", 32'(bus.mem_req), 32'd1);
        checkOutput("t6_restart_addr", 32'(bus.mem_addr), 32'd0);

        // Randomized traffic
        haltCycles = 0;
        for (int i = 0; i < 3000; i++) begin
            haltCycles = modelHalted ? haltCycles + 1 : 0;
            if (haltCycles >= 4 || $urandom_range(0, 599) == 0) begin
                doReset();
                haltCycles = 0;
            end else begin
                ack = bus.mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
                w   = DW'($urandom);
                applyStimulus(ack, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                              ($urandom_range(0, 7) == 0) ? 11'h7FF : w[AW-1:0]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
